countdown_timer: RTL and testbench

//  Game time-limit timer: counts a loaded MM:SS value down to 00:00 at 1 Hz and

---
 rtl/countdown_timer_pkg.sv | 85 ++++++++
 rtl/countdown_timer_tick_divider.sv | 30 +++
 rtl/countdown_timer.sv | 115 +++++++++++
 tb/tb_countdown_timer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types, 7-segment patterns and BCD helpers for the MM:SS countdown timer.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] clamp_digit(input logic [3:0] digit, input logic [3:0] limit);
        return (digit > limit) ? limit : digit;
    endfunction

    function automatic bcd_time_t sanitize(input logic [7:0] mins, input logic [7:0] secs);
        bcd_time_t t;
        t.m1 = clamp_digit(mins[7:4], 4'd9);
        t.m0 = clamp_digit(mins[3:0], 4'd9);
        t.s1 = clamp_digit(secs[7:4], 4'd5);
        t.s0 = clamp_digit(secs[3:0], 4'd9);
        return t;
    endfunction

    // Caller guarantees a non-zero time, so the borrow chain never underflows M1
    function automatic bcd_time_t bcd_decrement(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.s0 != 4'd0) begin
            n.s0 = t.s0 - 4'd1;
        end else begin
            n.s0 = 4'd9;
            if (t.s1 != 4'd0) begin
                n.s1 = t.s1 - 4'd1;
            end else begin
                n.s1 = 4'd5;
                if (t.m0 != 4'd0) begin
                    n.m0 = t.m0 - 4'd1;
                end else begin
                    n.m0 = 4'd9;
                    n.m1 = t.m1 - 4'd1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/countdown_timer_tick_divider.sv
// One-second tick generator: down-counter that pulses Tick on terminal count.
module countdown_timer_tick_divider #(
    parameter int CLOCK_FREQUENCY = 50000000
) (
    input  logic ClockIn,
    input  logic Reset,
    input  logic Clear,
    input  logic En,
    output logic Tick
);

    localparam int W = $clog2(CLOCK_FREQUENCY);
    localparam logic [W-1:0] TERM = W'(CLOCK_FREQUENCY - 1);

    logic [W-1:0] r_count;

    assign Tick = En && (r_count == '0);

    // Counting down from TERM gives a tick exactly CLOCK_FREQUENCY enabled cycles after a clear
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            r_count <= TERM;
        end else if (Clear) begin
            r_count <= TERM;
        end else if (En) begin
            r_count <= (r_count == '0) ? TERM : r_count - 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS game countdown timer with 1 Hz decrement, pause/resume and four 7-seg digits.
//   state    | meaning
//   ST_IDLE  | loaded value shown, waiting for Start
//   ST_RUN   | divider enabled, decrement on each tick
//   ST_PAUSE | count and partial second frozen
//   ST_DONE  | reached 00:00, only Load or Reset leave
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] LoadMin,
    input  logic [7:0] LoadSec,
    input  logic       Start,
    input  logic       Pause,
    output logic       Running,
    output logic       Expired,
    output logic       ExpiredPulse,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    state_t    r_state;
    state_t    w_state_next;
    bcd_time_t r_time;
    bcd_time_t w_time_next;
    logic      w_tick;
    logic      w_clear;
    logic      w_div_en;
    logic      w_time_zero;
    logic      w_time_one;

    assign w_div_en    = (r_state == ST_RUN);
    assign w_time_zero = (r_time == 16'h0000);
    assign w_time_one  = (r_time == 16'h0001);

    countdown_timer_tick_divider #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_tick_divider (
        .ClockIn(ClockIn),
        .Reset  (Reset),
        .Clear  (w_clear),
        .En     (w_div_en),
        .Tick   (w_tick)
    );

    // Load beats Pause beats Start in every state
    always_comb begin
        w_state_next = r_state;
        w_time_next  = r_time;
        w_clear      = 1'b0;
        if (Load) begin
            w_state_next = ST_IDLE;
            w_time_next  = sanitize(LoadMin, LoadSec);
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!Pause && Start && !w_time_zero) begin
                        w_state_next = ST_RUN;
                        w_clear      = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (Pause) begin
                        w_state_next = ST_PAUSE;
                    end else if (w_tick) begin
                        w_time_next = bcd_decrement(r_time);
                        if (w_time_one) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!Pause && Start) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_time       <= '0;
            Running      <= 1'b0;
            Expired      <= 1'b0;
            ExpiredPulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_time       <= w_time_next;
            Running      <= (w_state_next == ST_RUN);
            Expired      <= (w_state_next == ST_DONE);
            ExpiredPulse <= (r_state == ST_RUN) && (w_state_next == ST_DONE);
        end
    end

    assign hex0 = seg7(r_time.s0);
    assign hex1 = seg7(r_time.s1);
    assign hex2 = seg7(r_time.m0);
    assign hex3 = seg7(r_time.m1);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: per-cycle expectations from a seconds-based reference model.
module tb_countdown_timer;

    localparam int CF = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       ClockIn = 1'b0;
    logic       Reset   = 1'b1;
    logic       Load    = 1'b0;
    logic [7:0] LoadMin = 8'h00;
    logic [7:0] LoadSec = 8'h00;
    logic       Start   = 1'b0;
    logic       Pause   = 1'b0;
    logic       Running;
    logic       Expired;
    logic       ExpiredPulse;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;

    countdown_timer #(.CLOCK_FREQUENCY(CF)) dut (
        .ClockIn     (ClockIn),
        .Reset       (Reset),
        .Load        (Load),
        .LoadMin     (LoadMin),
        .LoadSec     (LoadSec),
        .Start       (Start),
        .Pause       (Pause),
        .Running     (Running),
        .Expired     (Expired),
        .ExpiredPulse(ExpiredPulse),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3)
    );

    always #5 ClockIn = ~ClockIn;

    typedef struct packed {
        logic       running;
        logic       expired;
        logic       pulse;
        logic [6:0] h3;
        logic [6:0] h2;
        logic [6:0] h1;
        logic [6:0] h0;
    } obs_t;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: remaining time as plain seconds
    int m_secs  = 0;
    int m_phase = 0;
    int m_mode  = M_IDLE;
    bit m_pulse = 1'b0;

    function automatic int clampi(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        int   mm;
        int   ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        o.running = (m_mode == M_RUN);
        o.expired = (m_mode == M_DONE);
        o.pulse   = m_pulse;
        o.h3      = seg_tab[mm / 10];
        o.h2      = seg_tab[mm % 10];
        o.h1      = seg_tab[ss / 10];
        o.h0      = seg_tab[ss % 10];
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.running = Running;
        o.expired = Expired;
        o.pulse   = ExpiredPulse;
        o.h3      = hex3;
        o.h2      = hex2;
        o.h1      = hex1;
        o.h0      = hex0;
        return o;
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_phase = 0;
        m_mode  = M_IDLE;
        m_pulse = 1'b0;
    endtask

    task automatic model_step(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                              input bit st, input bit ps);
        bit tick;
        m_pulse = 1'b0;
        if (ld) begin
            m_secs  = (clampi(int'(lm[7:4]), 9) * 10 + clampi(int'(lm[3:0]), 9)) * 60
                    +  clampi(int'(ls[7:4]), 5) * 10 + clampi(int'(ls[3:0]), 9);
            m_phase = 0;
            m_mode  = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (!ps && st && m_secs > 0) begin
                m_mode  = M_RUN;
                m_phase = 0;
            end
        end else if (m_mode == M_RUN) begin
            tick    = (m_phase == CF - 1);
            m_phase = (m_phase + 1) % CF;
            if (ps) begin
                m_mode = M_PAUSE;
            end else if (tick) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_mode  = M_DONE;
                    m_pulse = 1'b1;
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (!ps && st) m_mode = M_RUN;
        end
    endtask

    task automatic drive(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                         input bit st, input bit ps);
        @(negedge ClockIn);
        Load    = ld;
        LoadMin = lm;
        LoadSec = ls;
        Start   = st;
        Pause   = ps;
        model_step(ld, lm, ls, st, ps);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_hex(input string name, input logic [27:0] want);
        @(posedge ClockIn);
        #2;
        n_tests++;
        if ({hex3, hex2, hex1, hex0} !== want)
            $display("FAIL %s: got %b want %b", name, {hex3, hex2, hex1, hex0}, want);
        if ({hex3, hex2, hex1, hex0} !== want) n_fail++;
    endtask

    task automatic check_reset_now(input string name);
        obs_t want;
        obs_t got;
        want = '{running: 1'b0, expired: 1'b0, pulse: 1'b0,
                 h3: 7'b1000000, h2: 7'b1000000, h1: 7'b1000000, h0: 7'b1000000};
        got = dut_obs();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic async_reset();
        @(negedge ClockIn);
        Load  = 1'b0;
        Start = 1'b0;
        Pause = 1'b0;
        #1 Reset = 1'b1;
        #1 check_reset_now("async_reset");
        Reset = 1'b0;
        model_reset();
    endtask

    // Monitor: every cycle with a pending expectation is compared just after the edge
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(posedge ClockIn);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_obs();
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL cycle_obs t=%0t: got run=%b exp=%b pulse=%b hex=%b_%b_%b_%b want run=%b exp=%b pulse=%b hex=%b_%b_%b_%b",
                             $time, g.running, g.expired, g.pulse, g.h3, g.h2, g.h1, g.h0,
                             e.running, e.expired, e.pulse, e.h3, e.h2, e.h1, e.h0);
                end
            end
        end
    end

    initial begin
        bit         ld;
        bit         st;
        bit         ps;
        logic [7:0] lm;
        logic [7:0] ls;
        int         r;

        #1 check_reset_now("power_on_reset");
        @(negedge ClockIn);
        Reset = 1'b0;
        model_reset();

        // Expire from 00:03
        drive(1'b1, 8'h00, 8'h03, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(16);

        // 10:00 -> 09:59
        drive(1'b1, 8'h10, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(3);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check_hex("ten_min_borrow", {7'b1000000, 7'b0010000, 7'b0010010, 7'b0010000});

        // Pause keeps the partial second
        drive(1'b1, 8'h00, 8'h05, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(5);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(20);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(6);

        // Sanitised load, then Start at 00:00 is ignored
        drive(1'b1, 8'hAF, 8'h7C, 1'b0, 1'b0);
        check_hex("sanitise_99_59", {7'b0010000, 7'b0010000, 7'b0010010, 7'b0010000});
        drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(6);

        // Pause on the tick cycle, expire, Start/Pause in DONE, reload from DONE
        drive(1'b1, 8'h00, 8'h02, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(3);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(2);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(10);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 8'h00, 8'h07, 1'b1, 1'b0);
        idle(2);

        // Async reset while running
        drive(1'b1, 8'h00, 8'h09, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(5);
        async_reset();
        idle(3);

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            r  = int'($urandom_range(0, 99));
            ld = (r < 3);
            st = (r >= 3 && r < 13);
            ps = (r >= 13 && r < 17);
            lm = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
            ls = ($urandom_range(0, 2) == 0) ? 8'($urandom) : {4'h0, 4'($urandom_range(1, 6))};
            if (r == 17 && ($urandom_range(0, 9) == 0)) begin
                async_reset();
            end else begin
                drive(ld, lm, ls, st, ps);
            end
        end

        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge ClockIn);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
